// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared constants, state type and mixing helper for the audio PWM output
// stage (audio_pwm_out and its pwm_dac sub-module).
//   PWM_BITS   : PWM counter / duty width (carrier period = 2^PWM_BITS clocks)
//   SAMPLE_W   : width of one unsigned synthesiser sample
//   GAIN_MAX   : full-scale soft-start gain
//   GAIN_W     : width of the gain register (holds 0..GAIN_MAX)
//   GAIN_SHIFT : log2(GAIN_MAX); the scaled sample is (mixed * gain) >> GAIN_SHIFT
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int PWM_BITS   = 8;
    localparam int SAMPLE_W   = 8;
    localparam int GAIN_MAX   = 16;
    localparam int GAIN_W     = 5;
    localparam int GAIN_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } audio_state_t;

    // Sum of the enabled channels, attenuated by the volume shift and clipped
    // to full scale so a loud two-channel mix never wraps around.
    function automatic logic [SAMPLE_W-1:0] mixSample(
        input logic [SAMPLE_W-1:0] ch0,
        input logic                en0,
        input logic [SAMPLE_W-1:0] ch1,
        input logic                en1,
        input logic [1:0]          volShift
    );
        logic [SAMPLE_W:0] sum;
        logic [SAMPLE_W:0] shifted;
        sum     = {1'b0, (en0 ? ch0 : '0)} + {1'b0, (en1 ? ch1 : '0)};
        shifted = sum >> volShift;
        return (shifted > {1'b0, {SAMPLE_W{1'b1}}}) ? {SAMPLE_W{1'b1}} : shifted[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// ---------------------------------------------------------------------------
// audio_pwm_out_if
// Bundle between the sound-effect synthesisers / control logic and the
// audio PWM output stage.
//   enable      : level, 1 = audio on, 0 = fade out and shut amplifier down
//   ch0_in/en   : channel 0 unsigned sample and mix enable
//   ch1_in/en   : channel 1 unsigned sample and mix enable
//   vol_shift   : attenuation, mix right-shifted by 0..3
//   aud_pwm     : 1-bit PWM stream for the mono amplifier
//   aud_sd      : amplifier enable (1 = on)
//   sample_tick : one-cycle pulse on the last clock of each PWM period
//   busy        : output stage is not idle
// master = the side producing samples, slave = audio_pwm_out.
// ---------------------------------------------------------------------------
interface audio_pwm_out_if;

    logic       enable;
    logic [7:0] ch0_in;
    logic       ch0_en;
    logic [7:0] ch1_in;
    logic       ch1_en;
    logic [1:0] vol_shift;
    logic       aud_pwm;
    logic       aud_sd;
    logic       sample_tick;
    logic       busy;

    modport master (
        output enable, ch0_in, ch0_en, ch1_in, ch1_en, vol_shift,
        input  aud_pwm, aud_sd, sample_tick, busy
    );

    modport slave (
        input  enable, ch0_in, ch0_en, ch1_in, ch1_en, vol_shift,
        output aud_pwm, aud_sd, sample_tick, busy
    );

endinterface

// File: rtl/audio_pwm_out_pwm_dac.sv
// ---------------------------------------------------------------------------
// pwm_dac
// Free-running PWM carrier. The counter wraps every 2^WIDTH clocks, the duty
// value is captured only on the wrap edge so a period is never cut short or
// stretched, and the output bit is registered.
//   clk25       : system clock
//   reset       : synchronous, active-high
//   duty_in     : requested duty for the next period
//   aud_pwm     : registered PWM bit, equals (pwm_cnt < duty_q)
//   sample_tick : high while pwm_cnt is at its last count (period boundary)
// ---------------------------------------------------------------------------
module pwm_dac
    import audio_pkg::*;
#(
    parameter int WIDTH = PWM_BITS
) (
    input  logic             clk25,
    input  logic             reset,
    input  logic [WIDTH-1:0] duty_in,
    output logic             aud_pwm,
    output logic             sample_tick
);

    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    logic [WIDTH-1:0] r_pwmCnt;
    logic [WIDTH-1:0] r_dutyQ;
    logic             r_pwm;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cntNext;
    logic [WIDTH-1:0] w_dutyNext;

    assign w_wrap     = (r_pwmCnt == CNT_LAST);
    assign w_cntNext  = r_pwmCnt + 1'b1;
    assign w_dutyNext = w_wrap ? duty_in : r_dutyQ;

    // The output flop compares the values the counter and duty will hold
    // after this edge, so the registered bit lines up with pwm_cnt exactly.
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_pwmCnt <= '0;
            r_dutyQ  <= '0;
            r_pwm    <= 1'b0;
        end else begin
            r_pwmCnt <= w_cntNext;
            r_dutyQ  <= w_dutyNext;
            r_pwm    <= (w_cntNext < w_dutyNext);
        end
    end

    assign aud_pwm     = r_pwm;
    assign sample_tick = w_wrap;

endmodule

// File: rtl/audio_pwm_out.sv
// ---------------------------------------------------------------------------
// audio_pwm_out
// Output stage behind the sound-effect synthesisers: mixes two unsigned
// samples, applies a volume shift and an anti-pop soft-start/stop gain ramp,
// and drives the mono amplifier as 1-bit PWM with shutdown control.
// The board wrapper turns aud_pwm into the open-drain AUD_PWM pin
// (1 -> high-Z, 0 -> drive low) and feeds aud_sd straight to AUD_SD.
//   clk25    : 25 MHz system clock
//   reset    : synchronous, active-high
//   bus      : audio_pwm_out_if.slave (samples, enables, PWM/status outputs)
//   RAMP_DIV : PWM periods per gain step
// ---------------------------------------------------------------------------
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int RAMP_DIV = 64
) (
    input  logic            clk25,
    input  logic            reset,
    audio_pwm_out_if.slave  bus
);

    localparam int                 RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [GAIN_W-1:0]  GAIN_FULL = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0]  GAIN_TOP  = GAIN_W'(GAIN_MAX - 1);
    localparam int                 PROD_W    = SAMPLE_W + GAIN_W;

    audio_state_t        r_state;
    audio_state_t        w_stateNext;
    logic [GAIN_W-1:0]   r_gain;
    logic [GAIN_W-1:0]   w_gainNext;
    logic [RAMP_W-1:0]   r_rampCnt;
    logic [RAMP_W-1:0]   w_rampNext;
    logic [SAMPLE_W-1:0] r_mixed;
    logic [SAMPLE_W-1:0] r_scaled;
    logic [PROD_W-1:0]   w_product;
    logic [PROD_W-1:0]   w_scaledWide;
    logic                w_tick;
    logic                w_stepDue;

    // Two-stage mixer: stage 1 mixes/attenuates, stage 2 applies the ramp
    // gain. Both run every clock; the DAC only samples the result at the
    // period boundary.
    assign w_product    = {{GAIN_W{1'b0}}, r_mixed} * {{SAMPLE_W{1'b0}}, r_gain};
    assign w_scaledWide = w_product >> GAIN_SHIFT;

    always_ff @(posedge clk25) begin
        if (reset) begin
            r_mixed  <= '0;
            r_scaled <= '0;
        end else begin
            r_mixed  <= mixSample(bus.ch0_in, bus.ch0_en, bus.ch1_in, bus.ch1_en, bus.vol_shift);
            r_scaled <= (w_scaledWide > PROD_W'({SAMPLE_W{1'b1}})) ? {SAMPLE_W{1'b1}}
                                                                  : w_scaledWide[SAMPLE_W-1:0];
        end
    end

    pwm_dac #(
        .WIDTH (PWM_BITS)
    ) u_pwmDac (
        .clk25       (clk25),
        .reset       (reset),
        .duty_in     (r_scaled),
        .aud_pwm     (bus.aud_pwm),
        .sample_tick (w_tick)
    );

    // Gain only moves on period boundaries, once every RAMP_DIV periods.
    assign w_stepDue = w_tick && (r_rampCnt == RAMP_LAST);

    // State, gain and ramp divider registers.
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_state   <= IDLE;
            r_gain    <= '0;
            r_rampCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_gain    <= w_gainNext;
            r_rampCnt <= w_rampNext;
        end
    end

    // Soft-start/stop controller. A change of enable always takes priority
    // over a gain step on the same edge, and reversing direction keeps the
    // current gain so the output never jumps.
    always_comb begin
        w_stateNext = r_state;
        w_gainNext  = r_gain;
        w_rampNext  = r_rampCnt;
        unique case (r_state)
            IDLE: begin
                w_gainNext = '0;
                if (bus.enable) begin
                    w_stateNext = RAMP_UP;
                    w_rampNext  = '0;
                end
            end
            RAMP_UP: begin
                if (!bus.enable) begin
                    w_stateNext = RAMP_DOWN;
                    w_rampNext  = '0;
                end else if (w_stepDue) begin
                    w_rampNext = '0;
                    if (r_gain >= GAIN_TOP) begin
                        w_gainNext  = GAIN_FULL;
                        w_stateNext = ACTIVE;
                    end else begin
                        w_gainNext = r_gain + 1'b1;
                    end
                end else if (w_tick) begin
                    w_rampNext = r_rampCnt + 1'b1;
                end
            end
            ACTIVE: begin
                w_gainNext = GAIN_FULL;
                if (!bus.enable) begin
                    w_stateNext = RAMP_DOWN;
                    w_rampNext  = '0;
                end
            end
            RAMP_DOWN: begin
                if (bus.enable) begin
                    w_stateNext = RAMP_UP;
                    w_rampNext  = '0;
                end else if (w_stepDue) begin
                    w_rampNext = '0;
                    if (r_gain <= GAIN_W'(1)) begin
                        w_gainNext  = '0;
                        w_stateNext = IDLE;
                    end else begin
                        w_gainNext = r_gain - 1'b1;
                    end
                end else if (w_tick) begin
                    w_rampNext = r_rampCnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_gainNext  = '0;
                w_rampNext  = '0;
            end
        endcase
    end

    // The amplifier stays powered for the whole fade so the ramp is audible
    // rather than clipped by the shutdown pin.
    assign bus.aud_sd      = (r_state != IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.sample_tick = w_tick;

endmodule

// File: tb/tb_audio_pwm_out.sv
// ---------------------------------------------------------------------------
// tb_audio_pwm_out
// Bench for audio_pwm_out with a short ramp (RAMP_DIV = 2). The reference
// model works one PWM period at a time: the fade is a position along a line
// from 0 to 16*RAMP_DIV periods, the gain is that position divided by
// RAMP_DIV, and each period's duty is the previous period's mix times its
// gain over 16.
// ---------------------------------------------------------------------------
module tb_audio_pwm_out;

    localparam int RAMP_DIV = 2;
    localparam int PERIOD   = 256;
    localparam int FULL_POS = 16 * RAMP_DIV;

    logic clk25 = 1'b0;
    logic reset = 1'b1;

    audio_pwm_out_if bus();

    audio_pwm_out #(
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: fade position, direction, duty expected in the
    // period about to start, and the inputs currently applied.
    int rampPos   = 0;
    bit rampingUp = 1'b0;
    int expDuty   = 0;
    bit curEn     = 1'b0;
    int curC0     = 0;
    bit curE0     = 1'b0;
    int curC1     = 0;
    bit curE1     = 1'b0;
    int curVs     = 0;

    function automatic int mixRef(input int c0, input bit e0, input int c1, input bit e1, input int vs);
        int s;
        s = (e0 ? c0 : 0) + (e1 ? c1 : 0);
        s = s / (1 << vs);
        return (s > 255) ? 255 : s;
    endfunction

    // Rising: a gain step completes every RAMP_DIV periods; falling: the
    // gain only drops once a full RAMP_DIV periods have elapsed.
    function automatic int modelGain();
        return rampingUp ? (rampPos / RAMP_DIV) : ((rampPos + RAMP_DIV - 1) / RAMP_DIV);
    endfunction

    function automatic bit modelBusy();
        return rampingUp || (rampPos != 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        rampPos   = 0;
        rampingUp = 1'b0;
        expDuty   = 0;
        curEn     = 1'b0;
        curC0     = 0;
        curE0     = 1'b0;
        curC1     = 0;
        curE1     = 1'b0;
        curVs     = 0;
    endtask

    task automatic driveInputs();
        bus.enable    = curEn;
        bus.ch0_in    = curC0[7:0];
        bus.ch0_en    = curE0;
        bus.ch1_in    = curC1[7:0];
        bus.ch1_en    = curE1;
        bus.vol_shift = curVs[1:0];
    endtask

    // Waits (bounded) for the negedge on which sample_tick is high.
    task automatic syncToBoundary();
        int n;
        n = 0;
        do begin
            @(negedge clk25);
            n++;
        end while (!bus.sample_tick && n < 2 * PERIOD);
        checkOutput("syncTick", bus.sample_tick, 1);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        modelReset();
        driveInputs();
        repeat (3) @(negedge clk25);
        checkOutput("rstPwm", bus.aud_pwm, 0);
        checkOutput("rstSd", bus.aud_sd, 0);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstTick", bus.sample_tick, 0);
        reset = 1'b0;
        syncToBoundary();
    endtask

    // One full PWM period, starting just after a boundary. New inputs are
    // applied on the first clock; midC0 >= 0 replaces ch0 at pwm_cnt 100.
    task automatic applyStimulus(input bit en, input int c0, input bit e0, input int c1,
                                 input bit e1, input int vs, input int midC0);
        int highCount;
        int tickCount;
        int g;
        bit lastTick;
        highCount = 0;
        tickCount = 0;
        lastTick  = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk25);
            if (bus.aud_pwm === 1'b1) highCount++;
            if (bus.sample_tick === 1'b1) tickCount++;
            if (i == 0) begin
                if (en != rampingUp) begin
                    g         = modelGain();
                    rampingUp = en;
                    rampPos   = g * RAMP_DIV;
                end
                curEn = en;
                curC0 = c0;
                curE0 = e0;
                curC1 = c1;
                curE1 = e1;
                curVs = vs;
                driveInputs();
            end
            if (i == 100 && midC0 >= 0) begin
                curC0 = midC0;
                driveInputs();
            end
            if (i == PERIOD - 1) lastTick = bus.sample_tick;
        end
        checkOutput("highCount", highCount, expDuty);
        checkOutput("tickCount", tickCount, 1);
        checkOutput("tickAtEnd", lastTick, 1);
        checkOutput("busy", bus.busy, modelBusy());
        checkOutput("audSd", bus.aud_sd, modelBusy());
        expDuty = mixRef(curC0, curE0, curC1, curE1, curVs) * modelGain() / 16;
        if (rampingUp) rampPos = (rampPos + 1 > FULL_POS) ? FULL_POS : rampPos + 1;
        else           rampPos = (rampPos - 1 < 0) ? 0 : rampPos - 1;
    endtask

    initial begin
        bit rEn;
        int n;

        $display("[TB] audio_pwm_out bench start");

        // Reset, then amplifier off for four periods.
        resetDut();
        repeat (4) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, -1);

        // Soft start on a half-scale tone, through to ACTIVE.
        repeat (35) applyStimulus(1'b1, 8'h80, 1'b1, 0, 1'b0, 0, -1);
        checkOutput("activeGain", modelGain(), 16);

        // Two-channel mix and volume shifts at full gain.
        repeat (2) applyStimulus(1'b1, 200, 1'b1, 100, 1'b1, 0, -1);
        repeat (2) applyStimulus(1'b1, 200, 1'b1, 100, 1'b1, 1, -1);
        repeat (2) applyStimulus(1'b1, 200, 1'b1, 100, 1'b1, 2, -1);
        repeat (2) applyStimulus(1'b1, 200, 1'b1, 100, 1'b0, 0, -1);

        // Soft stop from full scale down to idle.
        repeat (34) applyStimulus(1'b0, 8'hFF, 1'b1, 0, 1'b0, 0, -1);

        // Up again, fade down to gain 8, then reverse back to ACTIVE.
        repeat (35) applyStimulus(1'b1, 8'hFF, 1'b1, 0, 1'b0, 0, -1);
        n = 0;
        do begin
            applyStimulus(1'b0, 8'hFF, 1'b1, 0, 1'b0, 0, -1);
            n++;
        end while (modelGain() != 8 && n < 40);
        checkOutput("reachedGain8", modelGain(), 8);
        applyStimulus(1'b1, 8'hFF, 1'b1, 0, 1'b0, 0, -1);
        checkOutput("reverseDuty", expDuty, 127);
        repeat (20) applyStimulus(1'b1, 8'hFF, 1'b1, 0, 1'b0, 0, -1);

        // Sample change mid-period must wait for the next period.
        applyStimulus(1'b1, 8'h40, 1'b1, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 8'h40, 1'b1, 0, 1'b0, 0, 8'hC0);
        applyStimulus(1'b1, 8'hC0, 1'b1, 0, 1'b0, 0, -1);

        // Randomised inputs and occasional enable flips.
        for (int k = 0; k < 30; k++) begin
            rEn = curEn;
            if ($urandom_range(0, 3) == 0) rEn = !rEn;
            if (!rEn && rampingUp && modelGain() == 0) rEn = 1'b1;
            applyStimulus(rEn, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), -1);
        end

        // Reset in the middle of a soft start.
        resetDut();
        repeat (6) applyStimulus(1'b1, 8'hFF, 1'b1, 0, 1'b0, 0, -1);
        repeat (10) @(negedge clk25);
        checkOutput("preResetPwm", bus.aud_pwm, (9 < expDuty) ? 1 : 0);
        checkOutput("preResetBusy", bus.busy, 1);
        reset      = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk25);
        checkOutput("midRstPwm", bus.aud_pwm, 0);
        checkOutput("midRstSd", bus.aud_sd, 0);
        checkOutput("midRstBusy", bus.busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk25);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
